// File: rtl/phase_bank_if.sv
// Shadow-bank write port of phase_bank_ctrl: valid/ready handshake plus channel, phase and enable.
// A write completes on a cycle where wr_valid && wr_ready; while wr_ready is low the master holds wr_valid and its data stable.
interface phase_bank_if #(
    parameter int CH_W    = 8,
    parameter int PHASE_W = 8
) ();
    logic               wr_valid;
    logic               wr_ready;
    logic [CH_W-1:0]    wr_channel;
    logic [PHASE_W-1:0] wr_phase;
    logic               wr_en;

    modport master (
        output wr_valid,
        output wr_channel,
        output wr_phase,
        output wr_en,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_channel,
        input  wr_phase,
        input  wr_en,
        output wr_ready
    );
endinterface

// File: rtl/phase_bank_ctrl.sv
// Double-buffered phase/enable bank: host writes the shadow bank, commit swaps banks at a PWM period boundary.
// Define PHASE_BANK_COPYBACK_EN to copy the new active bank back into the shadow after every swap.
module phase_bank_ctrl #(
    parameter int NUM_CHANNELS = 256,
    parameter int CLK_CNT_W    = 8,
    parameter int CLK_CNT_MAX  = 249,
    parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
    input  logic                              clk,
    input  logic                              rst,
    phase_bank_if.slave                       wr,
    input  logic                              commit,
    input  logic [CLK_CNT_W-1:0]              cnt,
    output logic [NUM_CHANNELS*CLK_CNT_W-1:0] phases,
    output logic [NUM_CHANNELS-1:0]           pwm_en,
    output logic                              commit_pending,
    output logic                              busy,
    output logic [15:0]                       frame_cnt,
    output logic                              err,
    output logic [1:0]                        dbg_state
);

    localparam logic [CLK_CNT_W-1:0] CNT_LAST = CLK_CNT_W'(CLK_CNT_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1
`ifdef PHASE_BANK_COPYBACK_EN
        ,
        COPY    = 2'd2
`endif
    } state_t;

    state_t state_q, state_d;
    logic   active_sel_q, active_sel_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic   err_q, err_d;

    // Index 0 is bank A, index 1 is bank B; active_sel_q picks the active one.
    logic [CLK_CNT_W-1:0] phase_bank_q [2][NUM_CHANNELS];
    logic [CLK_CNT_W-1:0] phase_bank_d [2][NUM_CHANNELS];
    logic                 en_bank_q    [2][NUM_CHANNELS];
    logic                 en_bank_d    [2][NUM_CHANNELS];

`ifdef PHASE_BANK_COPYBACK_EN
    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CHANNELS - 1);
    logic [CH_W-1:0] copy_idx_q, copy_idx_d;
`endif

    logic wr_fire;
    logic ch_in_range;

    assign wr.wr_ready    = (state_q == IDLE);
    assign wr_fire        = wr.wr_valid && (state_q == IDLE);
    assign ch_in_range    = (32'(wr.wr_channel) < 32'(NUM_CHANNELS));
    assign commit_pending = (state_q == PENDING);
    assign busy           = (state_q != IDLE);
    assign frame_cnt      = frame_cnt_q;
    assign err            = err_q;
    assign dbg_state      = state_q;

    always_comb begin
        phases = '0;
        pwm_en = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            phases[i*CLK_CNT_W +: CLK_CNT_W] = phase_bank_q[active_sel_q][i];
            pwm_en[i]                        = en_bank_q[active_sel_q][i];
        end
    end

    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        frame_cnt_d  = frame_cnt_q;
        err_d        = err_q;
        phase_bank_d = phase_bank_q;
        en_bank_d    = en_bank_q;
`ifdef PHASE_BANK_COPYBACK_EN
        copy_idx_d   = copy_idx_q;
`endif

        case (state_q)
            IDLE: begin
                // A write in the commit cycle lands before the swap, so it joins the committed frame.
                if (wr_fire) begin
                    if (ch_in_range) begin
                        phase_bank_d[~active_sel_q][wr.wr_channel] = wr.wr_phase;
                        en_bank_d[~active_sel_q][wr.wr_channel]    = wr.wr_en;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (commit) begin
                    state_d = PENDING;
                end
            end

            PENDING: begin
                if (commit) begin
                    err_d = 1'b1;
                end
                if (cnt == CNT_LAST) begin
                    active_sel_d = ~active_sel_q;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
`ifdef PHASE_BANK_COPYBACK_EN
                    state_d      = COPY;
                    copy_idx_d   = '0;
`else
                    state_d      = IDLE;
`endif
                end
            end

`ifdef PHASE_BANK_COPYBACK_EN
            COPY: begin
                if (commit) begin
                    err_d = 1'b1;
                end
                // active_sel_q already points at the freshly published bank here.
                phase_bank_d[~active_sel_q][copy_idx_q] = phase_bank_q[active_sel_q][copy_idx_q];
                en_bank_d[~active_sel_q][copy_idx_q]    = en_bank_q[active_sel_q][copy_idx_q];
                if (copy_idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    copy_idx_d = copy_idx_q + CH_W'(1);
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            active_sel_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_q        <= 1'b0;
            phase_bank_q <= '{default: '0};
            en_bank_q    <= '{default: 1'b0};
`ifdef PHASE_BANK_COPYBACK_EN
            copy_idx_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
            phase_bank_q <= phase_bank_d;
            en_bank_q    <= en_bank_d;
`ifdef PHASE_BANK_COPYBACK_EN
            copy_idx_q   <= copy_idx_d;
`endif
        end
    end

    // The frame counter may only advance out of PENDING.
    a_frame_only_from_pending: assert property (
        @(posedge clk) disable iff (rst) (state_q != PENDING) |=> $stable(frame_cnt_q)
    );

    a_legal_state: assert property (
        @(posedge clk) disable iff (rst) (state_q inside {IDLE, PENDING
`ifdef PHASE_BANK_COPYBACK_EN
                                                          , COPY
`endif
                                                          })
    );

endmodule

// File: tb/tb_phase_bank_ctrl.sv
// Directed bench for phase_bank_ctrl: 4-channel main instance plus a 5-channel instance for the out-of-range write.
// Expectations follow PHASE_BANK_COPYBACK_EN when it is defined for the build.
module tb_phase_bank_ctrl;

    localparam int N    = 4;
    localparam int N5   = 5;
    localparam int W    = 8;
    localparam int MAXC = 9;

`ifdef PHASE_BANK_COPYBACK_EN
    localparam logic [31:0] EXP_S3_PH = 32'h07090301;
    localparam logic [3:0]  EXP_S3_EN = 4'b1111;
    localparam logic [31:0] EXP_S4_PH = 32'h07090301;
    localparam logic        EXP_COPY  = 1'b1;
`else
    localparam logic [31:0] EXP_S3_PH = 32'h00090000;
    localparam logic [3:0]  EXP_S3_EN = 4'b0100;
    localparam logic [31:0] EXP_S4_PH = 32'h07050301;
    localparam logic        EXP_COPY  = 1'b0;
`endif

    // clock / reset / counter
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] cnt;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= (cnt == 8'(MAXC)) ? '0 : cnt + 8'd1;
    end

    // main instance
    phase_bank_if #(.CH_W(2), .PHASE_W(W)) wr_if ();
    logic              commit = 1'b0;
    logic [N*W-1:0]    phases;
    logic [N-1:0]      pwm_en;
    logic              commit_pending, busy, err;
    logic [15:0]       frame_cnt;
    logic [1:0]        dbg_state;

    phase_bank_ctrl #(.NUM_CHANNELS(N), .CLK_CNT_W(W), .CLK_CNT_MAX(MAXC)) dut (
        .clk(clk), .rst(rst), .wr(wr_if), .commit(commit), .cnt(cnt),
        .phases(phases), .pwm_en(pwm_en), .commit_pending(commit_pending),
        .busy(busy), .frame_cnt(frame_cnt), .err(err), .dbg_state(dbg_state)
    );

    // 5-channel instance
    phase_bank_if #(.CH_W(3), .PHASE_W(W)) wr5_if ();
    logic              commit5 = 1'b0;
    logic [N5*W-1:0]   phases5;
    logic [N5-1:0]     pwm_en5;
    logic              commit_pending5, busy5, err5;
    logic [15:0]       frame_cnt5;
    logic [1:0]        dbg_state5;

    phase_bank_ctrl #(.NUM_CHANNELS(N5), .CLK_CNT_W(W), .CLK_CNT_MAX(MAXC)) dut5 (
        .clk(clk), .rst(rst), .wr(wr5_if), .commit(commit5), .cnt(cnt),
        .phases(phases5), .pwm_en(pwm_en5), .commit_pending(commit_pending5),
        .busy(busy5), .frame_cnt(frame_cnt5), .err(err5), .dbg_state(dbg_state5)
    );

    // scoreboard counters
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks: all start and end on a falling edge
    task automatic wait_cnt(input logic [W-1:0] v);
        int k = 0;
        while (cnt !== v && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (cnt !== v) check("wait_cnt_timeout", 64'(cnt), 64'(v));
    endtask

    task automatic write_ch(input logic [1:0] ch, input logic [W-1:0] ph, input logic en);
        int k = 0;
        wr_if.wr_valid   = 1'b1;
        wr_if.wr_channel = ch;
        wr_if.wr_phase   = ph;
        wr_if.wr_en      = en;
        while (!wr_if.wr_ready && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!wr_if.wr_ready) check("write_ready_timeout", 64'(wr_if.wr_ready), 64'd1);
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic write5(input logic [2:0] ch, input logic [W-1:0] ph, input logic en);
        wr5_if.wr_valid   = 1'b1;
        wr5_if.wr_channel = ch;
        wr5_if.wr_phase   = ph;
        wr5_if.wr_en      = en;
        check("w5_ready", 64'(wr5_if.wr_ready), 64'd1);
        @(negedge clk);
        wr5_if.wr_valid = 1'b0;
    endtask

    initial begin
        int k;
        wr_if.wr_valid    = 1'b0;
        wr_if.wr_channel  = '0;
        wr_if.wr_phase    = '0;
        wr_if.wr_en       = 1'b0;
        wr5_if.wr_valid   = 1'b0;
        wr5_if.wr_channel = '0;
        wr5_if.wr_phase   = '0;
        wr5_if.wr_en      = 1'b0;

        // reset, no stimulus
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_phases", 64'(phases), 64'h0);
        check("rst_pwm_en", 64'(pwm_en), 64'h0);
        check("rst_wr_ready", 64'(wr_if.wr_ready), 64'd1);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pending", 64'(commit_pending), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);

        // out-of-range write on the 5-channel instance
        check("c5_err_before", 64'(err5), 64'd0);
        write5(3'd5, 8'h08, 1'b1);
        check("c5_err_oor", 64'(err5), 64'd1);
        write5(3'd1, 8'h04, 1'b1);
        commit5 = 1'b1;
        @(negedge clk);
        commit5 = 1'b0;
        k = 0;
        while (frame_cnt5 != 16'd1 && k < 25) begin
            @(negedge clk);
            k++;
        end
        check("c5_frame_cnt", 64'(frame_cnt5), 64'd1);
        check("c5_phases", 64'(phases5), 64'h0000000400);
        check("c5_pwm_en", 64'(pwm_en5), 64'b00010);
        check("c5_err_sticky", 64'(err5), 64'd1);
        repeat (6) @(negedge clk);

        // write ch0..3 then commit at cnt=2
        write_ch(2'd0, 8'd1, 1'b1);
        write_ch(2'd1, 8'd3, 1'b1);
        write_ch(2'd2, 8'd5, 1'b1);
        write_ch(2'd3, 8'd7, 1'b1);
        check("s2_shadow_invisible", 64'(phases), 64'h0);
        wait_cnt(8'd2);
        pulse_commit();
        check("s2_pending", 64'(commit_pending), 64'd1);
        check("s2_ready_low", 64'(wr_if.wr_ready), 64'd0);
        check("s2_busy_pending", 64'(busy), 64'd1);
        wait_cnt(8'd9);
        check("s2_pre_swap_phases", 64'(phases), 64'h0);
        check("s2_pre_swap_frame", 64'(frame_cnt), 64'd0);
        @(negedge clk);
        check("s2_swap_cnt", 64'(cnt), 64'd0);
        check("s2_phases", 64'(phases), 64'h07050301);
        check("s2_pwm_en", 64'(pwm_en), 64'hF);
        check("s2_frame_cnt", 64'(frame_cnt), 64'd1);
        check("s2_pending_clear", 64'(commit_pending), 64'd0);
        check("s2_busy_first", 64'(busy), 64'(EXP_COPY));
        wait_cnt(8'd3);
        check("s2_busy_last", 64'(busy), 64'(EXP_COPY));
        @(negedge clk);
        check("s2_busy_done", 64'(busy), 64'd0);
        check("s2_ready_back", 64'(wr_if.wr_ready), 64'd1);

        // incremental update of ch2 only
        write_ch(2'd2, 8'd9, 1'b1);
        pulse_commit();
        wait_cnt(8'd0);
        check("s3_phases", 64'(phases), 64'(EXP_S3_PH));
        check("s3_pwm_en", 64'(pwm_en), 64'(EXP_S3_EN));
        check("s3_frame_cnt", 64'(frame_cnt), 64'd2);

        // commit coincident with cnt=9 misses that boundary
        wait_cnt(8'd9);
        pulse_commit();
        check("s4_missed_frame", 64'(frame_cnt), 64'd2);
        check("s4_pending", 64'(commit_pending), 64'd1);
        k = 0;
        while (frame_cnt != 16'd3 && k < 25) begin
            @(negedge clk);
            k++;
        end
        check("s4_latency", 64'(k), 64'd10);
        check("s4_phases", 64'(phases), 64'(EXP_S4_PH));
        check("s4_pwm_en", 64'(pwm_en), 64'hF);

        // second commit while PENDING is dropped and flags err
        wait_cnt(8'd5);
        check("s5_err_before", 64'(err), 64'd0);
        pulse_commit();
        pulse_commit();
        check("s5_err_set", 64'(err), 64'd1);
        check("s5_still_pending", 64'(commit_pending), 64'd1);
        wait_cnt(8'd0);
        check("s5_frame_once", 64'(frame_cnt), 64'd4);
        @(negedge clk);
        wait_cnt(8'd0);
        check("s5_frame_stays", 64'(frame_cnt), 64'd4);
        check("s5_err_sticky", 64'(err), 64'd1);
        check("s5_idle_pending", 64'(commit_pending), 64'd0);

        // reset in the middle of a commit
        write_ch(2'd0, 8'd2, 1'b1);
        pulse_commit();
`ifdef PHASE_BANK_COPYBACK_EN
        wait_cnt(8'd0);
        check("s6_in_copy", 64'(dbg_state), 64'd2);
        check("s6_frame_before", 64'(frame_cnt), 64'd5);
`else
        wait_cnt(8'd5);
        check("s6_in_pending", 64'(dbg_state), 64'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s6_phases", 64'(phases), 64'h0);
        check("s6_pwm_en", 64'(pwm_en), 64'h0);
        check("s6_busy", 64'(busy), 64'd0);
        check("s6_pending", 64'(commit_pending), 64'd0);
        check("s6_frame_cnt", 64'(frame_cnt), 64'd0);
        check("s6_err", 64'(err), 64'd0);
        check("s6_ready", 64'(wr_if.wr_ready), 64'd1);
        check("s6_state", 64'(dbg_state), 64'd0);
        check("s6_err5", 64'(err5), 64'd0);
        repeat (25) @(negedge clk);
        check("s6_no_late_swap", 64'(frame_cnt), 64'd0);
        check("s6_phases_late", 64'(phases), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // global time limit
    initial begin
        #50000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
